// File: rtl/ts_pkg.sv
// rtl/ts_pkg.sv - shared constants and FSM encoding for the TS stream switch
package ts_pkg;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PKT_LEN   = 188;
  localparam int         NUM_STREAMS  = 4;

  typedef enum logic {
    HUNT = 1'b0,
    PASS = 1'b1
  } ts_state_e;

endpackage

// File: rtl/ts_byte_counter.sv
// rtl/ts_byte_counter.sv - packet byte position counter with wrap and first/last flags
module ts_byte_counter
  import ts_pkg::*;
#(
  parameter int PKT_LEN = TS_PKT_LEN
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic first_o,
  output logic last_o
);

  localparam int CW = $clog2(PKT_LEN);

  logic [CW-1:0] cnt_q, cnt_d;

  assign first_o = (cnt_q == '0);
  assign last_o  = (cnt_q == CW'(PKT_LEN - 1));

  // Next count: clear wins, otherwise advance one byte and wrap after the last one.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ts_switch_ctrl.sv
// rtl/ts_switch_ctrl.sv - 4:1 TS stream selector switching only on packet boundaries
module ts_switch_ctrl
  import ts_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = TS_PKT_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*DATA_WIDTH-1:0] data_in,
  input  logic [3:0]              valid_in,
  input  logic [3:0]              sync_in,
  input  logic [1:0]              sel_req,
  input  logic                    sel_req_valid,
  output logic [1:0]              mux_ctrl,
  output logic [9:0]              data_out_final,
  output logic                    switch_done,
  output logic                    sync_err
);

  ts_state_e       state_q, state_d;
  logic [1:0]      mux_q, mux_d;
  logic            pend_v_q, pend_v_d;
  logic [1:0]      pend_q, pend_d;
  logic [9:0]      dout_q, dout_d;
  logic            sd_q, se_q;

  logic            fwd, lose, sw;
  logic            cnt_first, cnt_last;
  logic            sel_valid, sel_sync;
  logic [DATA_WIDTH-1:0] byte_arr [NUM_STREAMS];
  logic [DATA_WIDTH-1:0] sel_byte;

  // Split the packed input bus into one byte lane per stream.
  always_comb begin
    for (int n = 0; n < NUM_STREAMS; n++) begin
      byte_arr[n] = data_in[n*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign sel_valid = valid_in[mux_q];
  assign sel_sync  = sync_in[mux_q];
  assign sel_byte  = byte_arr[mux_q];

  ts_byte_counter #(
    .PKT_LEN (PKT_LEN)
  ) u_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (sw | lose),
    .inc_i   (fwd),
    .first_o (cnt_first),
    .last_o  (cnt_last)
  );

  // Lock/forward decisions, boundary-aligned switching and pending-request bookkeeping.
  always_comb begin
    state_d  = state_q;
    mux_d    = mux_q;
    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    fwd      = 1'b0;
    lose     = 1'b0;
    sw       = 1'b0;
    case (state_q)
      HUNT: begin
        // Not inside a packet, so a waiting request can take effect right away.
        if (pend_v_q) begin
          sw = 1'b1;
        end else if (sel_valid && sel_sync) begin
          fwd     = 1'b1;
          state_d = PASS;
        end
      end
      PASS: begin
        if (sel_valid) begin
          if (cnt_first && !sel_sync) begin
            lose    = 1'b1;
            state_d = HUNT;
          end else begin
            fwd = 1'b1;
            sw  = cnt_last && pend_v_q;
          end
        end
      end
      default: state_d = HUNT;
    endcase
    if (sw) begin
      mux_d    = pend_q;
      pend_v_d = 1'b0;
      state_d  = HUNT;
    end
    // A new strobe is judged against the selection as it will be after this cycle.
    if (sel_req_valid && (pend_v_d || (sel_req != mux_d))) begin
      pend_v_d = 1'b1;
      pend_d   = sel_req;
    end
    dout_d = fwd ? {1'b1, sel_sync, 8'(sel_byte)} : 10'd0;
  end

  // State, selection, pending request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      mux_q    <= 2'd0;
      pend_v_q <= 1'b0;
      pend_q   <= 2'd0;
      dout_q   <= 10'd0;
      sd_q     <= 1'b0;
      se_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mux_q    <= mux_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
      dout_q   <= dout_d;
      sd_q     <= sw;
      se_q     <= lose;
    end
  end

  assign mux_ctrl       = mux_q;
  assign data_out_final = dout_q;
  assign switch_done    = sd_q;
  assign sync_err       = se_q;

endmodule

// File: tb/tb_ts_switch_ctrl.sv
// tb/tb_ts_switch_ctrl.sv - randomized and directed bench with a packet-level reference model
module tb_ts_switch_ctrl;

  localparam int L = 188;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [3:0]  valid_in, sync_in;
  logic [1:0]  sel_req;
  logic        sel_req_valid;
  logic [1:0]  mux_ctrl;
  logic [9:0]  data_out_final;
  logic        switch_done, sync_err;

  always #5 clk = ~clk;

  ts_switch_ctrl #(.DATA_WIDTH(8), .PKT_LEN(L)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .sync_in        (sync_in),
    .sel_req        (sel_req),
    .sel_req_valid  (sel_req_valid),
    .mux_ctrl       (mux_ctrl),
    .data_out_final (data_out_final),
    .switch_done    (switch_done),
    .sync_err       (sync_err)
  );

  int vectors = 0;
  int errors  = 0;

  // stream generators: next packet position per stream
  int  pos [4];
  int  vpct [4];
  bit  toggle0 = 0, tog = 0, corrupt0 = 0;
  bit  st_req = 0;
  logic [1:0] st_val = 2'd0;
  bit  chk_en = 0;

  // reference model: which stream is followed, whether we are inside one of its packets,
  // how many bytes of that packet have gone out, and the request waiting for a boundary
  int         m_mux = 0, m_inpkt = 0, m_sent = 0, m_have_req = 0, m_req = 0;
  logic [9:0] e_dout = 10'd0;
  bit         e_sd = 0, e_se = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mux = 0; m_inpkt = 0; m_sent = 0; m_have_req = 0; m_req = 0;
      e_dout = 10'd0; e_sd = 0; e_se = 0;
    end else begin
      bit v, s, took, done_pkt, lost, apply;
      logic [7:0] b;
      v = valid_in[m_mux];
      s = sync_in[m_mux];
      b = 8'(data_in >> (8 * m_mux));
      took = 0; done_pkt = 0; lost = 0;
      if (m_have_req && !m_inpkt) begin
        took = 0;
      end else if (v) begin
        if (!m_inpkt) begin
          if (s) begin took = 1; m_inpkt = 1; m_sent = 1; end
        end else if (m_sent == 0 && !s) begin
          lost = 1; m_inpkt = 0;
        end else begin
          took = 1;
          m_sent = m_sent + 1;
          if (m_sent == L) begin m_sent = 0; done_pkt = 1; end
        end
      end
      apply = m_have_req && (!m_inpkt || done_pkt);
      e_dout = took ? {1'b1, s, b} : 10'd0;
      e_sd = apply;
      e_se = lost;
      if (apply) begin
        m_mux = m_req; m_have_req = 0; m_inpkt = 0; m_sent = 0;
      end
      if (sel_req_valid && (m_have_req || int'(sel_req) != m_mux)) begin
        m_have_req = 1; m_req = int'(sel_req);
      end
    end
  end

  // cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (data_out_final !== e_dout || mux_ctrl !== 2'(m_mux) ||
          switch_done !== e_sd || sync_err !== e_se) begin
        errors++;
        $display("FAIL model_cmp t=%0t dout=%h exp=%h mux=%0d exp=%0d sd=%0b exp=%0b se=%0b exp=%0b",
                 $time, data_out_final, e_dout, mux_ctrl, m_mux, switch_done, e_sd, sync_err, e_se);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    for (int s = 0; s < 4; s++) begin
      bit v, sy;
      logic [7:0] b;
      if (s == 0 && toggle0) v = tog;
      else v = ($urandom_range(99) < vpct[s]);
      b  = 8'($urandom);
      sy = 1'($urandom);
      if (v) begin
        sy = (pos[s] == 0);
        b  = (pos[s] == 0) ? 8'h47 : {2'(s), 6'(pos[s])};
        if (s == 0 && pos[s] == 0 && corrupt0) begin
          sy = 1'b0; b = 8'h00; corrupt0 = 0;
        end
        pos[s] = (pos[s] + 1) % L;
      end
      valid_in[s] = v;
      sync_in[s]  = sy;
      data_in[s*8 +: 8] = b;
    end
    tog = ~tog;
    sel_req_valid = st_req;
    sel_req = st_req ? st_val : 2'($urandom);
    st_req = 0;
    @(negedge clk);
  endtask

  task automatic strobe(input logic [1:0] v);
    st_req = 1; st_val = v;
  endtask

  task automatic wait_valid(input string name, input int bound);
    int g = 0;
    while (!data_out_final[9] && g < bound) begin step(); g++; end
    chk(name, int'(data_out_final[9]), 1);
  endtask

  initial begin
    int n, sd, se, idle, seen1, tag1, g, badmux;
    rst = 1; valid_in = 0; sync_in = 0; data_in = 0; sel_req = 0; sel_req_valid = 0;
    for (int s = 0; s < 4; s++) begin vpct[s] = 100; pos[s] = $urandom_range(L - 1); end
    pos[0] = 180;
    @(negedge clk);
    step(); step();
    chk_en = 1;
    chk("rst_dout", int'(data_out_final), 0);
    chk("rst_mux", int'(mux_ctrl), 0);
    chk("rst_sd", int'(switch_done), 0);
    chk("rst_se", int'(sync_err), 0);
    rst = 0;

    // first lock on stream0 and one full packet
    wait_valid("lock0_wait", 400);
    chk("lock0_first", int'(data_out_final), 'h347);
    n = 1; se = 0; step(); g = 0;
    while (!(data_out_final[9] && data_out_final[8]) && g < 400) begin
      if (data_out_final[9]) n++;
      if (sync_err) se++;
      step(); g++;
    end
    chk("pkt0_len", n, L);
    chk("pkt0_syncerr", se, 0);

    // request stream2 at byte 50 of a stream0 packet
    g = 0;
    while (pos[0] != 50 && g < 400) begin step(); g++; end
    strobe(2'd2); step();
    n = 0; sd = 0; g = 0;
    while (g < 400) begin
      if (data_out_final[9]) n++;
      if (switch_done) sd++;
      if (mux_ctrl == 2'd2) break;
      step(); g++;
    end
    chk("sw2_tail_bytes", n, L - 50);
    chk("sw2_done_pulses", sd, 1);
    step();
    wait_valid("sw2_wait", 400);
    chk("sw2_first", int'(data_out_final), 'h347);
    chk("sw2_mux", int'(mux_ctrl), 2);

    // request 1 then 3 inside one packet: only 3 takes effect
    repeat (20) step();
    strobe(2'd1); step();
    repeat (30) step();
    strobe(2'd3); step();
    seen1 = 0; tag1 = 0; g = 0;
    while (mux_ctrl != 2'd3 && g < 400) begin
      if (mux_ctrl == 2'd1) seen1++;
      if (data_out_final[9] && !data_out_final[8] && data_out_final[7:6] == 2'd1) tag1++;
      step(); g++;
    end
    chk("sw3_mux", int'(mux_ctrl), 3);
    chk("sw3_never1", seen1, 0);
    chk("sw3_no_s1_bytes", tag1, 0);

    // back to stream0, then corrupt a sync byte
    strobe(2'd0); step();
    g = 0;
    while (mux_ctrl != 2'd0 && g < 400) begin step(); g++; end
    step();
    wait_valid("relock0_wait", 400);
    corrupt0 = 1;
    g = 0;
    while (!sync_err && g < 400) begin step(); g++; end
    chk("corrupt_syncerr", int'(sync_err), 1);
    idle = 0; se = 0; step(); g = 0;
    while (!data_out_final[9] && g < 400) begin
      idle++;
      if (sync_err) se++;
      step(); g++;
    end
    chk("corrupt_idle", idle, L - 1);
    chk("corrupt_extra_se", se, 0);
    chk("corrupt_relock", int'(data_out_final), 'h347);

    // stream0 valid on alternate cycles only
    toggle0 = 1;
    g = 0;
    while (!(data_out_final[9] && data_out_final[8]) && g < 1000) begin step(); g++; end
    n = 1; step(); g = 0;
    while (!(data_out_final[9] && data_out_final[8]) && g < 1000) begin
      if (data_out_final[9]) n++;
      step(); g++;
    end
    chk("toggle_pkt_len", n, L);
    toggle0 = 0;

    // reset mid-packet with a pending request
    g = 0;
    while (pos[0] != 100 && g < 400) begin step(); g++; end
    strobe(2'd3); step();
    repeat (4) step();
    rst = 1; step(); rst = 0;
    chk("midrst_mux", int'(mux_ctrl), 0);
    chk("midrst_dout", int'(data_out_final), 0);
    wait_valid("midrst_wait", 400);
    chk("midrst_first", int'(data_out_final), 'h347);
    sd = 0; badmux = 0;
    repeat (400) begin
      step();
      if (switch_done) sd++;
      if (mux_ctrl != 2'd0) badmux++;
    end
    chk("midrst_no_switch", sd, 0);
    chk("midrst_mux_held", badmux, 0);

    // randomized traffic against the model
    for (int c = 0; c < 6000; c++) begin
      if (c % 500 == 0)
        for (int s = 0; s < 4; s++) vpct[s] = 50 + $urandom_range(50);
      if ($urandom_range(99) < 2) strobe(2'($urandom));
      if ($urandom_range(999) < 3) corrupt0 = 1;
      rst = ($urandom_range(999) == 0);
      step();
    end
    rst = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
